orx_ant_sequencer: RTL and testbench
====================================

ORX_ANT_SEQUENCER -- requirements
Module: orx_ant_sequencer

Interface
REQ-001 Parameter ANT_NUM, default 8, number of antenna paths (2..16).
REQ-002 Parameter SETTLE_CYC, default 50, switch settling time in clk_in cycles (~200 ns at 245.76 MHz), range 1..4095.
REQ-003 Parameter DWELL_CYC, default 1024, ORx capture window per antenna in clk_in cycles, range 1..4095.
REQ-004 clk_in  input  1  single clock of the block, rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 i_Tx_stt  input  1  all-TX-on status from the TDD controller; high = ORx sweep permitted.
REQ-007 i_enable  input  1  software sweep enable.
REQ-008 i_ant_mask  input  ANT_NUM  per-antenna include bits; bit k = 1 sweeps antenna k.
REQ-009 o_sw_sel  output  ANT_NUM  one-hot ORx RF switch select; all-zero = no path.
REQ-010 o_ant_idx  output  $clog2(ANT_NUM)  index of the antenna currently selected.
REQ-011 o_cap_valid  output  1  high while ORx samples are valid for capture.
REQ-012 o_cycle_done  output  1  one-cycle pulse at the end of a complete sweep.
REQ-013 o_busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, SELECT, SETTLE, DWELL; all outputs registered.
REQ-015 IDLE -> SELECT when i_Tx_stt = 1, i_enable = 1 and i_ant_mask != 0; otherwise remain in IDLE.
REQ-016 SELECT lasts exactly 1 cycle: i_ant_mask sampled; target = lowest set mask bit with index >= search pointer; if none, lowest set bit overall (wrap); o_ant_idx and o_sw_sel updated on exit from SELECT.
REQ-017 SETTLE lasts exactly SETTLE_CYC cycles with o_cap_valid = 0, then -> DWELL.
REQ-018 DWELL lasts exactly DWELL_CYC cycles with o_cap_valid = 1, then -> SELECT with search pointer = o_ant_idx + 1 (wraps ANT_NUM-1 -> 0).
REQ-019 o_cycle_done SHALL pulse in the last DWELL cycle when the mask sampled in SELECT has no set bit above o_ant_idx; a single-bit mask pulses every dwell.
REQ-020 Search pointer SHALL be 0 on entry from IDLE; each sweep therefore starts at the lowest enabled antenna.
REQ-021 i_Tx_stt = 0 or i_enable = 0 in any non-IDLE state: next cycle -> IDLE, o_sw_sel = 0, o_cap_valid = 0, no o_cycle_done pulse.
REQ-022 Mask becoming all-zero in SELECT: -> IDLE with outputs cleared; mask changes during SETTLE/DWELL take effect at the next SELECT only.
REQ-023 Settle/dwell counter 12 bits, cleared on every state entry; o_sw_sel SHALL never have more than one bit set.
REQ-024 In IDLE o_sw_sel = 0, o_cap_valid = 0, o_busy = 0; o_ant_idx holds last value.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, search pointer 0, o_sw_sel 0, o_ant_idx 0, o_cap_valid 0, o_cycle_done 0, o_busy 0.
REQ-026 After rst_n deasserts, the first possible SELECT is the second rising clk_in edge.

Configuration
REQ-027 Macro ORX_SWEEP_CNT_EN defined: additional output o_sweep_cnt [15:0], incremented on each o_cycle_done, saturating at 16'hFFFF, cleared by reset only.
REQ-028 Macro ORX_SWEEP_CNT_EN undefined: port o_sweep_cnt and its counter absent; all other behaviour identical.

Verification
REQ-029 Mask 8'hFF, SETTLE_CYC 4, DWELL_CYC 8, i_Tx_stt/i_enable held high -> o_ant_idx 0..7 in order, each o_cap_valid window 8 cycles preceded by 4 settle cycles, o_cycle_done once after antenna 7, sweep restarts at 0.
REQ-030 Mask 8'b1010_0100 -> only indices 2, 5, 7 selected; o_cycle_done in last DWELL cycle of index 7.
REQ-031 Single-bit mask 8'h08 -> o_sw_sel stays 8'h08, o_cycle_done every 1+4+8 = 13 cycles.
REQ-032 i_Tx_stt drops in 3rd DWELL cycle of index 4 -> next cycle o_sw_sel 0, o_cap_valid 0, o_busy 0, no o_cycle_done; on i_Tx_stt reassert sweep restarts at lowest set bit.
REQ-033 rst_n asserted mid-SETTLE (asynchronously, between edges) -> all outputs cleared without waiting for clk_in.
REQ-034 With ORX_SWEEP_CNT_EN and 3 full sweeps -> o_sweep_cnt = 3; force to 16'hFFFF then 1 more sweep -> stays 16'hFFFF.

Source files
------------

// File: rtl/orx_ant_sequencer.sv
// rtl/orx_ant_sequencer.sv - ORx antenna sweep sequencer (optional sweep counter via ORX_SWEEP_CNT_EN)
module orx_ant_sequencer #(
  parameter int ANT_NUM    = 8,
  parameter int SETTLE_CYC = 50,
  parameter int DWELL_CYC  = 1024
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic                       i_Tx_stt,
  input  logic                       i_enable,
  input  logic [ANT_NUM-1:0]         i_ant_mask,
  output logic [ANT_NUM-1:0]         o_sw_sel,
  output logic [$clog2(ANT_NUM)-1:0] o_ant_idx,
  output logic                       o_cap_valid,
  output logic                       o_cycle_done,
`ifdef ORX_SWEEP_CNT_EN
  output logic [15:0]                o_sweep_cnt,
`endif
  output logic                       o_busy
);

  localparam int IW = $clog2(ANT_NUM);
  localparam logic [11:0]   SETTLE_LAST = 12'(SETTLE_CYC - 1);
  localparam logic [11:0]   DWELL_LAST  = 12'(DWELL_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(ANT_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SETTLE, S_DWELL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [11:0]         r_cnt;
  logic [11:0]         w_cnt_nxt;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       w_ptr_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic                r_rst_done;
  logic [ANT_NUM-1:0]  r_sw_sel;
  logic [ANT_NUM-1:0]  w_sw_sel_nxt;
  logic [IW-1:0]       r_ant_idx;
  logic [IW-1:0]       w_ant_idx_nxt;
  logic                r_cap_valid;
  logic                w_cap_valid_nxt;
  logic                r_cycle_done;
  logic                w_cycle_done_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  logic                w_go;
  logic                w_hit_hi;
  logic                w_hit_any;
  logic [IW-1:0]       w_tgt_hi;
  logic [IW-1:0]       w_tgt_lo;
  logic [IW-1:0]       w_target;
  logic                w_above;

  assign w_go = i_Tx_stt & i_enable;

  // Target search: lowest set bit at/above the pointer, else wrap to lowest set bit
  always_comb begin
    w_hit_hi  = 1'b0;
    w_hit_any = 1'b0;
    w_tgt_hi  = '0;
    w_tgt_lo  = '0;
    for (int k = ANT_NUM - 1; k >= 0; k--) begin
      if (i_ant_mask[k]) begin
        w_tgt_lo  = IW'(k);
        w_hit_any = 1'b1;
        if (k >= int'(r_ptr)) begin
          w_tgt_hi = IW'(k);
          w_hit_hi = 1'b1;
        end
      end
    end
    w_target = w_hit_hi ? w_tgt_hi : w_tgt_lo;
    w_above  = 1'b0;
    for (int k = 0; k < ANT_NUM; k++) begin
      if (i_ant_mask[k] && (k > int'(w_target))) begin
        w_above = 1'b1;
      end
    end
  end

  // State register; r_rst_done delays the first SELECT by one edge after reset release
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Next-state logic; losing TX-on or enable aborts from any active state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go && r_rst_done && w_hit_any) w_state_nxt = S_SELECT;
      end
      S_SELECT: begin
        if (!w_go || !w_hit_any) w_state_nxt = S_IDLE;
        else                     w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (!w_go)                     w_state_nxt = S_IDLE;
        else if (r_cnt == SETTLE_LAST) w_state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (!w_go)                    w_state_nxt = S_IDLE;
        else if (r_cnt == DWELL_LAST) w_state_nxt = S_SELECT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if ((w_state_nxt == S_IDLE) || (w_state_nxt != r_state)) w_cnt_nxt = '0;
    else                                                     w_cnt_nxt = r_cnt + 12'd1;
  end

  // Output logic: values computed from the next state so the registered outputs align with it
  always_comb begin
    w_sw_sel_nxt  = r_sw_sel;
    w_ant_idx_nxt = r_ant_idx;
    w_ptr_nxt     = r_ptr;
    w_last_nxt    = r_last;
    if (w_state_nxt == S_IDLE) begin
      w_sw_sel_nxt = '0;
      w_ptr_nxt    = '0;
    end
    if ((r_state == S_SELECT) && (w_state_nxt == S_SETTLE)) begin
      w_ant_idx_nxt = w_target;
      w_sw_sel_nxt  = ANT_NUM'(1) << w_target;
      w_last_nxt    = ~w_above;
    end
    if ((r_state == S_DWELL) && (w_state_nxt == S_SELECT)) begin
      w_ptr_nxt = (r_ant_idx == IDX_LAST) ? '0 : r_ant_idx + IW'(1);
    end
    w_cap_valid_nxt  = (w_state_nxt == S_DWELL);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_cycle_done_nxt = (w_state_nxt == S_DWELL) && (w_cnt_nxt == DWELL_LAST) && r_last;
  end

  // Output and sweep-pointer registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_sel     <= '0;
      r_ant_idx    <= '0;
      r_ptr        <= '0;
      r_last       <= 1'b0;
      r_cap_valid  <= 1'b0;
      r_cycle_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sw_sel     <= w_sw_sel_nxt;
      r_ant_idx    <= w_ant_idx_nxt;
      r_ptr        <= w_ptr_nxt;
      r_last       <= w_last_nxt;
      r_cap_valid  <= w_cap_valid_nxt;
      r_cycle_done <= w_cycle_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

`ifdef ORX_SWEEP_CNT_EN
  logic [15:0] r_sweep_cnt;

  // Completed-sweep counter, saturating, cleared only by reset
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sweep_cnt <= '0;
    end else if (w_cycle_done_nxt && (r_sweep_cnt != 16'hFFFF)) begin
      r_sweep_cnt <= r_sweep_cnt + 16'd1;
    end
  end

  assign o_sweep_cnt = r_sweep_cnt;
`endif

  assign o_sw_sel     = r_sw_sel;
  assign o_ant_idx    = r_ant_idx;
  assign o_cap_valid  = r_cap_valid;
  assign o_cycle_done = r_cycle_done;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_orx_ant_sequencer.sv
// tb/tb_orx_ant_sequencer.sv - directed self-checking bench for orx_ant_sequencer
module tb_orx_ant_sequencer;

  localparam int SC = 4;
  localparam int DC = 8;

  logic       clk_in;
  logic       rst_n;
  logic       i_Tx_stt;
  logic       i_enable;
  logic [7:0] i_ant_mask;
  logic [7:0] o_sw_sel;
  logic [2:0] o_ant_idx;
  logic       o_cap_valid;
  logic       o_cycle_done;
  logic       o_busy;
`ifdef ORX_SWEEP_CNT_EN
  logic [15:0] o_sweep_cnt;
`endif

  int total;
  int bad;

  // {busy, cap_valid, cycle_done, sw_sel, ant_idx}
  wire [13:0] obs = {o_busy, o_cap_valid, o_cycle_done, o_sw_sel, o_ant_idx};

  orx_ant_sequencer #(.ANT_NUM(8), .SETTLE_CYC(SC), .DWELL_CYC(DC)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .i_Tx_stt     (i_Tx_stt),
    .i_enable     (i_enable),
    .i_ant_mask   (i_ant_mask),
    .o_sw_sel     (o_sw_sel),
    .o_ant_idx    (o_ant_idx),
    .o_cap_valid  (o_cap_valid),
    .o_cycle_done (o_cycle_done),
`ifdef ORX_SWEEP_CNT_EN
    .o_sweep_cnt  (o_sweep_cnt),
`endif
    .o_busy       (o_busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_Tx_stt = 1'b1; i_enable = 1'b1; i_ant_mask = 8'hFF;
    #12;
    total++;
    if (obs !== 14'h0) begin bad++; $display("FAIL reset_vals got=%h want=%h", obs, 14'h0); end
    rst_n = 1'b1;
    tick;
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_first_edge busy got=%b want=0", o_busy); end
    tick;
    total++;
    if (obs !== {3'b100, 8'h00, 3'd0}) begin bad++; $display("FAIL reset_second_edge got=%h want=%h", obs, {3'b100, 8'h00, 3'd0}); end
    i_enable = 1'b0;
    tick;
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_abort busy got=%b want=0", o_busy); end
  endtask

  task automatic test_sweep(input logic [7:0] m, input int nsw);
    logic [7:0] oh;
    logic [13:0] exp;
    int hi;
    hi = 0;
    for (int k = 0; k < 8; k++) if (m[k]) hi = k;
    i_ant_mask = m; i_Tx_stt = 1'b1; i_enable = 1'b1;
    tick;
    total++;
    if (obs[13:3] !== {3'b100, 8'h00}) begin bad++; $display("FAIL sweep_entry m=%h got=%h want=%h", m, obs[13:3], {3'b100, 8'h00}); end
    for (int s = 0; s < nsw; s++) begin
      for (int a = 0; a < 8; a++) begin
        if (m[a]) begin
          oh = 8'h01 << a;
          exp = {3'b100, oh, 3'(a)};
          tick;
          total++;
          if (obs !== exp) begin bad++; $display("FAIL select_exit m=%h a=%0d got=%h want=%h", m, a, obs, exp); end
          for (int j = 1; j < SC; j++) begin
            tick;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL settle m=%h a=%0d j=%0d got=%h want=%h", m, a, j, obs, exp); end
          end
          for (int j = 0; j < DC; j++) begin
            exp = {2'b11, (a == hi) && (j == DC - 1), oh, 3'(a)};
            tick;
            total++;
            if (obs !== exp) begin bad++; $display("FAIL dwell m=%h a=%0d j=%0d got=%h want=%h", m, a, j, obs, exp); end
          end
          exp = {3'b100, oh, 3'(a)};
          tick;
          total++;
          if (obs !== exp) begin bad++; $display("FAIL reselect m=%h a=%0d got=%h want=%h", m, a, obs, exp); end
        end
      end
    end
    i_enable = 1'b0;
    tick;
    exp = {3'b000, 8'h00, 3'(hi)};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL sweep_idle m=%h got=%h want=%h", m, obs, exp); end
  endtask

  task automatic test_tx_drop;
    int n;
    i_ant_mask = 8'hFF; i_Tx_stt = 1'b1; i_enable = 1'b1;
    n = 0;
    tick;
    while (!(o_ant_idx == 3'd4 && o_cap_valid) && n < 200) begin tick; n++; end
    total++;
    if (!(o_ant_idx == 3'd4 && o_cap_valid)) begin bad++; $display("FAIL txdrop_reach idx got=%0d want=4", o_ant_idx); end
    tick;
    tick;
    i_Tx_stt = 1'b0;
    tick;
    total++;
    if (obs !== {3'b000, 8'h00, 3'd4}) begin bad++; $display("FAIL txdrop_abort got=%h want=%h", obs, {3'b000, 8'h00, 3'd4}); end
    i_Tx_stt = 1'b1;
    tick;
    total++;
    if (obs[13:3] !== {3'b100, 8'h00}) begin bad++; $display("FAIL txdrop_reselect got=%h want=%h", obs[13:3], {3'b100, 8'h00}); end
    tick;
    total++;
    if (obs !== {3'b100, 8'h01, 3'd0}) begin bad++; $display("FAIL txdrop_restart got=%h want=%h", obs, {3'b100, 8'h01, 3'd0}); end
    i_enable = 1'b0;
    tick;
  endtask

  task automatic test_mask_change;
    i_ant_mask = 8'h01; i_Tx_stt = 1'b1; i_enable = 1'b1;
    tick;
    tick;
    repeat (SC - 1) tick;
    tick;
    i_ant_mask = 8'h00;
    tick;
    total++;
    if (obs !== {3'b110, 8'h01, 3'd0}) begin bad++; $display("FAIL maskchg_dwell got=%h want=%h", obs, {3'b110, 8'h01, 3'd0}); end
    repeat (DC - 3) tick;
    tick;
    total++;
    if (obs !== {3'b111, 8'h01, 3'd0}) begin bad++; $display("FAIL maskchg_done got=%h want=%h", obs, {3'b111, 8'h01, 3'd0}); end
    tick;
    total++;
    if (obs !== {3'b100, 8'h01, 3'd0}) begin bad++; $display("FAIL maskchg_select got=%h want=%h", obs, {3'b100, 8'h01, 3'd0}); end
    tick;
    total++;
    if (obs !== {3'b000, 8'h00, 3'd0}) begin bad++; $display("FAIL maskzero_idle got=%h want=%h", obs, {3'b000, 8'h00, 3'd0}); end
    i_enable = 1'b0;
  endtask

  task automatic test_async_reset;
    i_ant_mask = 8'hFF; i_Tx_stt = 1'b1; i_enable = 1'b1;
    tick;
    tick;
    tick;
    total++;
    if (obs !== {3'b100, 8'h01, 3'd0}) begin bad++; $display("FAIL areset_pre got=%h want=%h", obs, {3'b100, 8'h01, 3'd0}); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 14'h0) begin bad++; $display("FAIL areset_clear got=%h want=%h", obs, 14'h0); end
    i_enable = 1'b0;
    #2;
    rst_n = 1'b1;
    tick;
    tick;
  endtask

`ifdef ORX_SWEEP_CNT_EN
  task automatic test_sweep_cnt;
    test_sweep(8'h08, 3);
    total++;
    if (o_sweep_cnt !== 16'd3) begin bad++; $display("FAIL sweep_cnt got=%0d want=3", o_sweep_cnt); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_sweep(8'hFF, 2);
    test_sweep(8'b1010_0100, 1);
    test_sweep(8'h08, 2);
    test_tx_drop;
    test_mask_change;
    test_async_reset;
`ifdef ORX_SWEEP_CNT_EN
    test_sweep_cnt;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
